rps_match_ctrl: RTL and testbench
=================================

RPS_MATCH_CTRL -- requirements
Module: rps_match_ctrl

Interface
REQ-001 Parameter WIN_ROUNDS, default 3: round wins needed to end a match; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 15: cycles a submitted player waits for the opponent before forfeit; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk.
REQ-005 start  in  1  request a new match; honoured only in IDLE or DONE.
REQ-006 p1_valid / p2_valid  in  1  player move offered this cycle.
REQ-007 p1_move / p2_move  in  2  move code: 0 = none/illegal, 1 = rock, 2 = paper, 3 = scissor.
REQ-008 p1_ready / p2_ready  out  1  controller will latch that player's move this cycle.
REQ-009 round_done  out  1  one-cycle pulse when a round result is published.
REQ-010 round_result  out  2  0 = tie, 1 = player 1, 2 = player 2; held until the next round_done.
REQ-011 score1 / score2 / ties  out  8  running counts for the current match.
REQ-012 match_done  out  1  level; high in DONE.
REQ-013 match_winner  out  2  1 or 2; valid while match_done is high, 0 otherwise.
REQ-014 busy  out  1  high in every state except IDLE and DONE.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, EVAL, REPORT and DONE.
REQ-016 IDLE/DONE + start: clear the scores, ties, round_result and match_winner, then go to COLLECT next cycle.
REQ-017 start in any other state SHALL be ignored.
REQ-018 COLLECT: px_ready is high only while player x's move is not yet latched.
REQ-019 A move is latched on a cycle with px_valid & px_ready; later valid pulses from that player are ignored for the round.
REQ-020 Both players latching in the same cycle is legal.
REQ-021 COLLECT -> EVAL on the cycle after both moves are latched.
REQ-022 Timeout timer: resets to 0 on entry to COLLECT and increments only while exactly one move is latched.
REQ-023 Timer reaching TIMEOUT: the latched player wins the round (forfeit) and the FSM goes to EVAL.
REQ-024 With no move latched, COLLECT waits indefinitely.
REQ-025 EVAL (one cycle) judging rules: rock beats scissor, scissor beats paper, paper beats rock; equal legal moves tie.
REQ-026 An illegal move (0) loses to any legal move; two illegal moves tie.
REQ-027 In EVAL, the FSM registers round_result and increments exactly one of score1, score2 or ties; all three saturate at 255.
REQ-028 REPORT (one cycle): round_done = 1 and the updated counts are visible; go to DONE if score1 or score2 equals WIN_ROUNDS, else to COLLECT with both latches cleared.
REQ-029 Latency: both moves latched at edge N -> round_done high in cycle N+2.
REQ-030 DONE: match_done = 1 and match_winner set; scores are held until start.

Reset
REQ-031 On rst low, asynchronously: state = IDLE; all outputs, counts, latches and timer = 0.
REQ-032 Reset mid-round SHALL discard latched moves with no round_done pulse.

Structure
REQ-033 Shared package rps_pkg SHALL hold move_t (NONE/ROCK/PAPER/SCISSOR), result_t (TIE/P1/P2) and the FSM state enum.
REQ-034 A combinational sub-module rps_judge(move1, move2 -> result_t) SHALL implement REQ-025/026; the judging rules SHALL be implemented only there.
REQ-035 Target size: 120-400 lines of RTL.

Verification
REQ-036 start; p1 = rock, p2 = scissor in the same cycle -> round_done 2 cycles later, round_result = 1, score1 = 1.
REQ-037 p1 = paper at cycle 0, p2 never valid, TIMEOUT = 15 -> forfeit; round_result = 1, score1 incremented, no ready to p2 after EVAL.
REQ-038 Three player-2 wins in a row with WIN_ROUNDS = 3 -> match_done = 1, match_winner = 2, busy = 0; a further p1_valid is not accepted.
REQ-039 Tie paper/paper, then illegal/illegal -> ties = 2, scores = 0; p1 = 0 vs p2 = rock -> round_result = 2.
REQ-040 rst asserted in COLLECT with one move latched -> all outputs 0 immediately, IDLE, no round_done pulse; a following start yields a clean match.
REQ-041 start pulsed during COLLECT -> ignored, scores unchanged.

Source files
------------

// File: rtl/rps_pkg.sv
// rps_pkg: shared move, result and FSM state types for the rock-paper-scissor match controller
package rps_pkg;

   typedef enum logic [1:0] {NONE = 2'd0, ROCK = 2'd1, PAPER = 2'd2, SCISSOR = 2'd3} move_t;
   typedef enum logic [1:0] {TIE = 2'd0, P1 = 2'd1, P2 = 2'd2} result_t;
   typedef enum logic [2:0] {ST_IDLE, ST_COLLECT, ST_EVAL, ST_REPORT, ST_DONE} state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/rps_judge.sv
// rps_judge: combinational round judge; an illegal move loses to any legal one
module rps_judge import rps_pkg::*; (
   input  move_t   move1,
   input  move_t   move2,
   output result_t result
);

   logic p1_beats;

   assign p1_beats = (move1 == ROCK    && move2 == SCISSOR) ||
                     (move1 == SCISSOR && move2 == PAPER)   ||
                     (move1 == PAPER   && move2 == ROCK);
   assign result   = (move1 == move2) ? TIE : (move2 == NONE || p1_beats) ? P1 : P2;

endmodule

// File: rtl/rps_match_ctrl.sv
// rps_match_ctrl: two-player rock-paper-scissor match controller with forfeit timeout
module rps_match_ctrl import rps_pkg::*; #(
   parameter int unsigned WIN_ROUNDS = 3,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       p1_valid,
   input  logic       p2_valid,
   input  logic [1:0] p1_move,
   input  logic [1:0] p2_move,
   output logic       p1_ready,
   output logic       p2_ready,
   output logic       round_done,
   output logic [1:0] round_result,
   output logic [7:0] score1,
   output logic [7:0] score2,
   output logic [7:0] ties,
   output logic       match_done,
   output logic [1:0] match_winner,
   output logic       busy
);

   state_t     state_q;
   logic       l1_q, l2_q;
   move_t      m1_q, m2_q;
   logic [7:0] timer_q, s1_q, s2_q, t_q;
   result_t    res_q, judged, eval_d;
   logic       done_q, mdone_q;
   logic [1:0] win_q;

   rps_judge u_judge (
      .move1  (m1_q),
      .move2  (m2_q),
      .result (judged)
   );

   // a lone latched move wins by forfeit; otherwise the judge decides
   assign eval_d       = (l1_q & l2_q) ? judged : (l1_q ? P1 : P2);
   assign p1_ready     = (state_q == ST_COLLECT) & ~l1_q;
   assign p2_ready     = (state_q == ST_COLLECT) & ~l2_q;
   assign busy         = (state_q != ST_IDLE) & (state_q != ST_DONE);
   assign round_done   = done_q;
   assign round_result = res_q;
   assign score1       = s1_q;
   assign score2       = s2_q;
   assign ties         = t_q;
   assign match_done   = mdone_q;
   assign match_winner = win_q;

   // match FSM: move collection, forfeit timer, scoring and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         l1_q    <= 1'b0;
         l2_q    <= 1'b0;
         m1_q    <= NONE;
         m2_q    <= NONE;
         timer_q <= 8'd0;
         s1_q    <= 8'd0;
         s2_q    <= 8'd0;
         t_q     <= 8'd0;
         res_q   <= TIE;
         done_q  <= 1'b0;
         mdone_q <= 1'b0;
         win_q   <= 2'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q <= ST_COLLECT;
                  l1_q    <= 1'b0;
                  l2_q    <= 1'b0;
                  timer_q <= 8'd0;
                  s1_q    <= 8'd0;
                  s2_q    <= 8'd0;
                  t_q     <= 8'd0;
                  res_q   <= TIE;
                  mdone_q <= 1'b0;
                  win_q   <= 2'd0;
               end
            end
            ST_COLLECT: begin
               if (p1_valid & ~l1_q) begin
                  l1_q <= 1'b1;
                  m1_q <= move_t'(p1_move);
               end
               if (p2_valid & ~l2_q) begin
                  l2_q <= 1'b1;
                  m2_q <= move_t'(p2_move);
               end
               if (l1_q & l2_q) begin
                  state_q <= ST_EVAL;
               end else if (l1_q ^ l2_q) begin
                  timer_q <= timer_q + 8'd1;
                  if (timer_q == 8'(TIMEOUT - 1)) state_q <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               res_q   <= eval_d;
               s1_q    <= (eval_d == P1)  ? sat_inc(s1_q) : s1_q;
               s2_q    <= (eval_d == P2)  ? sat_inc(s2_q) : s2_q;
               t_q     <= (eval_d == TIE) ? sat_inc(t_q)  : t_q;
               done_q  <= 1'b1;
               state_q <= ST_REPORT;
            end
            ST_REPORT: begin
               if (s1_q == 8'(WIN_ROUNDS) || s2_q == 8'(WIN_ROUNDS)) begin
                  state_q <= ST_DONE;
                  mdone_q <= 1'b1;
                  win_q   <= (s1_q == 8'(WIN_ROUNDS)) ? 2'd1 : 2'd2;
               end else begin
                  state_q <= ST_COLLECT;
                  l1_q    <= 1'b0;
                  l2_q    <= 1'b0;
                  timer_q <= 8'd0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// tb_rps_match_ctrl: table-driven and directed checks for rps_match_ctrl
module tb_rps_match_ctrl;
   import rps_pkg::*;

   logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic       p1_valid = 1'b0, p2_valid = 1'b0;
   logic [1:0] p1_move = 2'd0, p2_move = 2'd0;
   logic       p1_ready, p2_ready, round_done, match_done, busy;
   logic [1:0] round_result, match_winner;
   logic [7:0] score1, score2, ties;
   int         checks = 0, errors = 0;

   typedef struct {
      logic [1:0] m1, m2, res;
      logic [7:0] s1, s2, t;
      logic       done;
   } vec_t;

   vec_t tbl[8];

   rps_match_ctrl #(.WIN_ROUNDS(3), .TIMEOUT(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .p1_valid     (p1_valid),
      .p2_valid     (p2_valid),
      .p1_move      (p1_move),
      .p2_move      (p2_move),
      .p1_ready     (p1_ready),
      .p2_ready     (p2_ready),
      .round_done   (round_done),
      .round_result (round_result),
      .score1       (score1),
      .score2       (score2),
      .ties         (ties),
      .match_done   (match_done),
      .match_winner (match_winner),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start_match;
      start = 1'b1;
      tick;
      start = 1'b0;
      check("start_busy", 32'(busy), 1);
      check("start_score1", 32'(score1), 0);
      check("start_score2", 32'(score2), 0);
      check("start_ties", 32'(ties), 0);
      check("start_match_done", 32'(match_done), 0);
   endtask

   task automatic play_round(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] res,
                             input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] t,
                             input logic done);
      p1_valid = 1'b1;
      p2_valid = 1'b1;
      p1_move  = m1;
      p2_move  = m2;
      tick;
      p1_valid = 1'b0;
      p2_valid = 1'b0;
      check("ready_after_latch", 32'({p1_ready, p2_ready}), 0);
      tick;
      check("round_done_early", 32'(round_done), 0);
      tick;
      check("round_done", 32'(round_done), 1);
      check("round_result", 32'(round_result), 32'(res));
      check("score1", 32'(score1), 32'(s1));
      check("score2", 32'(score2), 32'(s2));
      check("ties", 32'(ties), 32'(t));
      tick;
      check("round_done_pulse", 32'(round_done), 0);
      check("match_done", 32'(match_done), 32'(done));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      tbl[0] = '{ROCK,    SCISSOR, P1,  8'd1, 8'd0, 8'd0, 1'b0};
      tbl[1] = '{PAPER,   PAPER,   TIE, 8'd1, 8'd0, 8'd1, 1'b0};
      tbl[2] = '{NONE,    NONE,    TIE, 8'd1, 8'd0, 8'd2, 1'b0};
      tbl[3] = '{NONE,    ROCK,    P2,  8'd1, 8'd1, 8'd2, 1'b0};
      tbl[4] = '{SCISSOR, PAPER,   P1,  8'd2, 8'd1, 8'd2, 1'b0};
      tbl[5] = '{ROCK,    PAPER,   P2,  8'd2, 8'd2, 8'd2, 1'b0};
      tbl[6] = '{SCISSOR, SCISSOR, TIE, 8'd2, 8'd2, 8'd3, 1'b0};
      tbl[7] = '{SCISSOR, ROCK,    P2,  8'd2, 8'd3, 8'd3, 1'b1};
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'({p1_ready, p2_ready}), 0);
      check("rst_round_done", 32'(round_done), 0);
      check("rst_scores", 32'({score1, score2, ties}), 0);
      check("rst_match", 32'({match_done, match_winner, round_result}), 0);
      tick;
      rst = 1'b1;
      tick;
      check("idle_busy", 32'(busy), 0);
      start_match;
      check("collect_ready", 32'({p1_ready, p2_ready}), 3);
      for (int i = 0; i < 8; i++)
         play_round(tbl[i].m1, tbl[i].m2, tbl[i].res, tbl[i].s1, tbl[i].s2, tbl[i].t, tbl[i].done);
      check("tbl_winner", 32'(match_winner), 2);
      check("tbl_busy", 32'(busy), 0);
      start_match;
      check("restart_winner", 32'(match_winner), 0);
      for (int k = 1; k <= 3; k++)
         play_round(PAPER, SCISSOR, P2, 8'd0, 8'(k), 8'd0, k == 3);
      check("p2win_winner", 32'(match_winner), 2);
      check("p2win_busy", 32'(busy), 0);
      p1_valid = 1'b1;
      p1_move  = ROCK;
      check("done_p1_ready", 32'(p1_ready), 0);
      tick;
      p1_valid = 1'b0;
      tick;
      check("done_held_scores", 32'({score1, score2}), 32'({8'd0, 8'd3}));
      check("done_held_match", 32'(match_done), 1);
      start_match;
      p1_valid = 1'b1;
      p1_move  = PAPER;
      tick;
      p1_valid = 1'b0;
      n = 0;
      while (!round_done && n < 50) begin
         tick;
         n++;
      end
      check("forfeit_latency", 32'(n), 16);
      check("forfeit_result", 32'(round_result), 1);
      check("forfeit_score1", 32'(score1), 1);
      check("forfeit_score2", 32'(score2), 0);
      check("forfeit_ready", 32'({p1_ready, p2_ready}), 0);
      tick;
      check("forfeit_match_done", 32'(match_done), 0);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("ignored_start_busy", 32'(busy), 1);
      check("ignored_start_score1", 32'(score1), 1);
      check("ignored_start_ready", 32'(p1_ready), 1);
      play_round(ROCK, SCISSOR, P1, 8'd2, 8'd0, 8'd0, 1'b0);
      p1_valid = 1'b1;
      p1_move  = ROCK;
      tick;
      p1_valid = 1'b0;
      check("midround_latched", 32'(p1_ready), 0);
      #2 rst = 1'b0;
      #1;
      check("async_rst_scores", 32'({score1, score2, ties}), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_ready", 32'({p1_ready, p2_ready}), 0);
      check("async_rst_outs", 32'({round_done, round_result, match_done, match_winner}), 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("rst_no_round_done", 32'(round_done), 0);
      end
      rst = 1'b1;
      tick;
      check("post_rst_idle", 32'(busy), 0);
      check("post_rst_round_done", 32'(round_done), 0);
      start_match;
      play_round(SCISSOR, PAPER, P1, 8'd1, 8'd0, 8'd0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
